// File: rtl/stage3_fetch_stage.sv
// rtl/stage3_fetch_stage.sv - instruction fetch stage producing the fetch->execute pipeline register
//
// Purpose
//   Owns the PC and issues one instruction-memory request at a time. Each
//   completed fetch becomes an entry carrying pc, pc+4, the instruction word,
//   the branch prediction and fault/misalignment information. Entries enter
//   the fetch->execute register, or a one-entry hold buffer while execute
//   stalls. Redirects from the mem stage either retarget the PC directly or,
//   when a request is still outstanding, wait in DRAIN for that response and
//   discard it.
//
// Ports
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   imem_ren/imem_addr         fetch request and address (address = pc)
//   imem_rdata/imem_fault      response word and access fault, valid when imem_ren && !imem_busy
//   imem_busy                  request not yet complete
//   bp_pc/bp_taken/bp_target   branch predictor lookup (bp_pc = pc) and its answer
//   redirect_valid/redirect_pc mem-stage redirect
//   stall_f/flush_f            hazard unit hold / squash of the fetch->execute register
//   fetch_busy                 outstanding request in RUN, to the hazard unit
//   fe_*                       fetch->execute pipeline register

module stage3_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busy,
  input  logic        imem_fault,
  output logic [31:0] bp_pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_f,
  input  logic        flush_f,
  output logic        fetch_busy,
  output logic        fe_valid,
  output logic        fe_prediction,
  output logic        fe_mal_insn,
  output logic        fe_fault_insn,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_pc4,
  output logic [31:0] fe_instr,
  output logic [31:0] fe_badaddr
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        prediction;
    logic        mal_insn;
    logic        fault_insn;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] badaddr;
  } fe_entry_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        hold_valid;
  fe_entry_t   hold_q;
  fe_entry_t   fe_q;

  logic        mal;
  logic        done;
  logic        form;
  logic        bad;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  fe_entry_t   entry;

  assign mal      = (pc[1:0] != 2'b00);
  // In DRAIN the request stays asserted so the outstanding access can finish.
  assign imem_ren = (state == RUN) ? (!hold_valid && !mal) : 1'b1;
  assign imem_addr = pc;
  assign bp_pc     = pc;
  assign done      = imem_ren && !imem_busy;
  // Misaligned PCs form an entry without touching memory.
  assign form      = (state == RUN) && !hold_valid && (mal || done);
  assign fetch_busy = (state == RUN) && imem_ren && imem_busy;

  assign pc_plus4 = pc + 32'd4;
  assign bad      = mal || imem_fault;
  // A misaligned entry never trusts the predictor.
  assign next_pc  = (!mal && bp_taken) ? bp_target : pc_plus4;

  always_comb begin
    entry            = '0;
    entry.valid      = 1'b1;
    entry.prediction = !mal && bp_taken;
    entry.mal_insn   = mal;
    entry.fault_insn = !mal && imem_fault;
    entry.pc         = pc;
    entry.pc4        = pc_plus4;
    entry.instr      = bad ? 32'h0 : imem_rdata;
    entry.badaddr    = bad ? pc : 32'h0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      pc         <= RESET_PC;
      pend_pc    <= RESET_PC;
      hold_valid <= 1'b0;
      hold_q     <= '0;
      fe_q       <= '0;
    end else if (redirect_valid) begin
      fe_q.valid <= 1'b0;
      hold_valid <= 1'b0;
      // A request in flight cannot be aborted: park the target until it returns.
      // In DRAIN imem_ren is high, so a second redirect just replaces pend_pc.
      if (imem_ren && imem_busy) begin
        pend_pc <= redirect_pc;
        state   <= DRAIN;
      end else begin
        pc    <= redirect_pc;
        state <= RUN;
      end
    end else if (state == DRAIN) begin
      fe_q.valid <= 1'b0;
      if (!imem_busy) begin
        pc    <= pend_pc;
        state <= RUN;
      end
    end else begin
      if (form) begin
        pc <= next_pc;
      end
      if (flush_f && !stall_f) begin
        fe_q <= '0;
      end else if (stall_f) begin
        if (form) begin
          hold_q     <= entry;
          hold_valid <= 1'b1;
        end
      end else if (hold_valid) begin
        fe_q       <= hold_q;
        hold_valid <= 1'b0;
      end else if (form) begin
        fe_q <= entry;
      end else begin
        fe_q.valid <= 1'b0;
      end
    end
  end

  assign fe_valid      = fe_q.valid;
  assign fe_prediction = fe_q.prediction;
  assign fe_mal_insn   = fe_q.mal_insn;
  assign fe_fault_insn = fe_q.fault_insn;
  assign fe_pc         = fe_q.pc;
  assign fe_pc4        = fe_q.pc4;
  assign fe_instr      = fe_q.instr;
  assign fe_badaddr    = fe_q.badaddr;

endmodule

// File: tb/tb_stage3_fetch_stage.sv
// tb/tb_stage3_fetch_stage.sv - self-checking bench for stage3_fetch_stage

module tb_stage3_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        CLK;
  logic        nRST;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_busy;
  logic        imem_fault;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_f;
  logic        flush_f;
  logic        fetch_busy;
  logic        fe_valid;
  logic        fe_prediction;
  logic        fe_mal_insn;
  logic        fe_fault_insn;
  logic [31:0] fe_pc;
  logic [31:0] fe_pc4;
  logic [31:0] fe_instr;
  logic [31:0] fe_badaddr;

  int cnt_total = 0;
  int cnt_bad   = 0;

  stage3_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_busy(imem_busy), .imem_fault(imem_fault),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_f(stall_f), .flush_f(flush_f), .fetch_busy(fetch_busy),
    .fe_valid(fe_valid), .fe_prediction(fe_prediction),
    .fe_mal_insn(fe_mal_insn), .fe_fault_insn(fe_fault_insn),
    .fe_pc(fe_pc), .fe_pc4(fe_pc4), .fe_instr(fe_instr), .fe_badaddr(fe_badaddr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic        pr;
    logic        ml;
    logic        ft;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic [31:0] bad;
  } ent_t;

  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_drain;
  ent_t        m_hold[$];
  ent_t        m_fe;

  task automatic model_reset();
    m_pc    = RST_PC;
    m_pend  = RST_PC;
    m_drain = 0;
    m_hold.delete();
    m_fe    = '0;
  endtask

  function automatic bit m_mal();
    return m_pc[1:0] != 2'b00;
  endfunction

  function automatic bit m_ren();
    if (m_drain) return 1'b1;
    return (m_hold.size() == 0) && !m_mal();
  endfunction

  // One rising edge, applying the stage rules in priority order.
  task automatic model_update();
    bit   mal, ren, outstanding, formed;
    ent_t e;
    logic [31:0] nxt;
    mal         = m_mal();
    ren         = m_ren();
    outstanding = ren && imem_busy;
    formed      = !m_drain && (m_hold.size() == 0) && (mal || (ren && !imem_busy));
    e.v   = 1'b1;
    e.pc  = m_pc;
    e.pc4 = m_pc + 32'd4;
    e.pr  = mal ? 1'b0 : bp_taken;
    e.ml  = mal;
    e.ft  = mal ? 1'b0 : imem_fault;
    e.ins = (mal || imem_fault) ? 32'h0 : mem_word(m_pc);
    e.bad = (mal || imem_fault) ? m_pc : 32'h0;
    nxt   = (!mal && bp_taken) ? bp_target : m_pc + 32'd4;
    if (redirect_valid) begin
      m_fe.v = 1'b0;
      m_hold.delete();
      if (outstanding) begin
        m_pend  = redirect_pc;
        m_drain = 1;
      end else begin
        m_pc    = redirect_pc;
        m_drain = 0;
      end
    end else if (m_drain) begin
      m_fe.v = 1'b0;
      if (!imem_busy) begin
        m_pc    = m_pend;
        m_drain = 0;
      end
    end else begin
      if (formed) m_pc = nxt;
      if (flush_f && !stall_f) m_fe = '0;
      else if (stall_f) begin
        if (formed) m_hold.push_back(e);
      end else if (m_hold.size() != 0) m_fe = m_hold.pop_front();
      else if (formed) m_fe = e;
      else m_fe.v = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr_inputs();
    imem_busy      = 0;
    imem_fault     = 0;
    bp_taken       = 0;
    bp_target      = 32'h0;
    redirect_valid = 0;
    redirect_pc    = 32'h0;
    stall_f        = 0;
    flush_f        = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    cnt_total++;
    if (fe_valid !== 1'b0) begin cnt_bad++; $display("FAIL reset_fe_valid got=%0b exp=0", fe_valid); end
    cnt_total++;
    if ({fe_pc, fe_instr, fe_badaddr} !== 96'h0) begin
      cnt_bad++; $display("FAIL reset_fe_words got=%h exp=0", {fe_pc, fe_instr, fe_badaddr});
    end
    cnt_total++;
    if (imem_addr !== RST_PC || bp_pc !== RST_PC) begin
      cnt_bad++; $display("FAIL reset_addr got=%h/%h exp=%h", imem_addr, bp_pc, RST_PC);
    end
    cnt_total++;
    if (imem_ren !== 1'b1) begin cnt_bad++; $display("FAIL reset_ren got=%0b exp=1", imem_ren); end
  endtask

  task automatic test_sequential();
    clr_inputs();
    nRST = 1;
    model_reset();
    settle();
    cnt_total++;
    if (imem_addr !== 32'h8000_0000 || imem_ren !== 1'b1) begin
      cnt_bad++; $display("FAIL seq_addr0 got=%h ren=%0b exp=80000000", imem_addr, imem_ren);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h8000_0000 + 32'(i * 4);
      step();
      cnt_total++;
      if (fe_valid !== 1'b1 || fe_pc !== a || fe_pc4 !== a + 32'd4 || fe_instr !== mem_word(a)) begin
        cnt_bad++;
        $display("FAIL seq_fe%0d got v=%0b pc=%h pc4=%h ins=%h exp pc=%h", i, fe_valid, fe_pc, fe_pc4, fe_instr, a);
      end
      cnt_total++;
      if (imem_addr !== a + 32'd4) begin
        cnt_bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i + 1, imem_addr, a + 32'd4);
      end
    end
  endtask

  task automatic test_predict();
    do_reset();
    settle();
    step();
    bp_taken  = 1;
    bp_target = 32'h8000_0100;
    settle();
    step();
    bp_taken = 0;
    cnt_total++;
    if (fe_prediction !== 1'b1 || fe_pc !== 32'h8000_0004) begin
      cnt_bad++; $display("FAIL predict_fe got pred=%0b pc=%h exp pred=1 pc=80000004", fe_prediction, fe_pc);
    end
    cnt_total++;
    if (imem_addr !== 32'h8000_0100) begin
      cnt_bad++; $display("FAIL predict_addr got=%h exp=80000100", imem_addr);
    end
  endtask

  task automatic test_redirect_drain();
    imem_busy = 1;
    settle();
    cnt_total++;
    if (fetch_busy !== 1'b1) begin cnt_bad++; $display("FAIL drain_fetch_busy0 got=%0b exp=1", fetch_busy); end
    step();
    redirect_valid = 1;
    redirect_pc    = 32'h8000_0040;
    settle();
    step();
    redirect_valid = 0;
    settle();
    cnt_total++;
    if (fe_valid !== 1'b0 || fetch_busy !== 1'b0 || imem_ren !== 1'b1 || imem_addr !== 32'h8000_0100) begin
      cnt_bad++;
      $display("FAIL drain_state got v=%0b fb=%0b ren=%0b addr=%h exp 0/0/1/80000100", fe_valid, fetch_busy, imem_ren, imem_addr);
    end
    step();
    imem_busy = 0;
    settle();
    step();
    cnt_total++;
    if (fe_valid !== 1'b0 || imem_addr !== 32'h8000_0040) begin
      cnt_bad++; $display("FAIL drain_exit got v=%0b addr=%h exp v=0 addr=80000040", fe_valid, imem_addr);
    end
    step();
    cnt_total++;
    if (fe_valid !== 1'b1 || fe_pc !== 32'h8000_0040) begin
      cnt_bad++; $display("FAIL drain_first got v=%0b pc=%h exp v=1 pc=80000040", fe_valid, fe_pc);
    end
  endtask

  task automatic test_stall();
    stall_f = 1;
    settle();
    step();
    settle();
    cnt_total++;
    if (imem_ren !== 1'b0 || fe_pc !== 32'h8000_0040) begin
      cnt_bad++; $display("FAIL stall_hold got ren=%0b pc=%h exp ren=0 pc=80000040", imem_ren, fe_pc);
    end
    step();
    stall_f = 0;
    settle();
    step();
    cnt_total++;
    if (fe_valid !== 1'b1 || fe_pc !== 32'h8000_0044 || fe_instr !== mem_word(32'h8000_0044)) begin
      cnt_bad++; $display("FAIL stall_release got v=%0b pc=%h ins=%h exp pc=80000044", fe_valid, fe_pc, fe_instr);
    end
    step();
    cnt_total++;
    if (fe_pc !== 32'h8000_0048) begin cnt_bad++; $display("FAIL stall_next got=%h exp=80000048", fe_pc); end
  endtask

  task automatic test_fault();
    do_reset();
    settle();
    repeat (4) step();
    imem_fault = 1;
    settle();
    step();
    imem_fault = 0;
    cnt_total++;
    if (fe_fault_insn !== 1'b1 || fe_badaddr !== 32'h8000_0010 || fe_instr !== 32'h0 || fe_pc !== 32'h8000_0010) begin
      cnt_bad++;
      $display("FAIL fault_entry got ft=%0b bad=%h ins=%h pc=%h exp 1/80000010/0", fe_fault_insn, fe_badaddr, fe_instr, fe_pc);
    end
  endtask

  task automatic test_mal();
    redirect_valid = 1;
    redirect_pc    = 32'h8000_0022;
    settle();
    step();
    redirect_valid = 0;
    settle();
    cnt_total++;
    if (imem_ren !== 1'b0) begin cnt_bad++; $display("FAIL mal_ren got=%0b exp=0", imem_ren); end
    step();
    cnt_total++;
    if (fe_valid !== 1'b1 || fe_mal_insn !== 1'b1 || fe_badaddr !== 32'h8000_0022 || fe_instr !== 32'h0
        || fe_pc4 !== 32'h8000_0026 || fe_prediction !== 1'b0) begin
      cnt_bad++;
      $display("FAIL mal_entry got v=%0b ml=%0b bad=%h ins=%h pc4=%h", fe_valid, fe_mal_insn, fe_badaddr, fe_instr, fe_pc4);
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    imem_busy = 1;
    settle();
    step();
    redirect_valid = 1;
    redirect_pc    = 32'h8000_0080;
    settle();
    step();
    redirect_valid = 0;
    settle();
    cnt_total++;
    if (fetch_busy !== 1'b0) begin cnt_bad++; $display("FAIL rstdrain_in_drain got=%0b exp=0", fetch_busy); end
    nRST = 0;
    #1;
    cnt_total++;
    if (fe_valid !== 1'b0 || imem_addr !== RST_PC || imem_ren !== 1'b1 || fetch_busy !== 1'b1) begin
      cnt_bad++;
      $display("FAIL rstdrain_async got v=%0b addr=%h ren=%0b fb=%0b exp 0/80000000/1/1", fe_valid, imem_addr, imem_ren, fetch_busy);
    end
    imem_busy = 0;
    @(posedge CLK);
    #1;
    nRST = 1;
    model_reset();
    settle();
    step();
    cnt_total++;
    if (fe_valid !== 1'b1 || fe_pc !== RST_PC) begin
      cnt_bad++; $display("FAIL rstdrain_after got v=%0b pc=%h exp v=1 pc=80000000", fe_valid, fe_pc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      imem_busy      = ($urandom_range(0, 9) < 3);
      imem_fault     = ($urandom_range(0, 15) == 0);
      bp_taken       = ($urandom_range(0, 4) == 0);
      bp_target      = RST_PC + {22'h0, 8'($urandom_range(0, 255)), 2'b00}
                       + (($urandom_range(0, 19) == 0) ? 32'd2 : 32'd0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = RST_PC + {22'h0, 8'($urandom_range(0, 255)), 2'b00}
                       + 32'($urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0);
      stall_f        = ($urandom_range(0, 4) == 0);
      flush_f        = ($urandom_range(0, 9) == 0);
      settle();
      cnt_total++;
      if (imem_ren !== m_ren() || imem_addr !== m_pc || bp_pc !== m_pc) begin
        cnt_bad++;
        $display("FAIL rand_req cyc=%0d got ren=%0b addr=%h bp=%h exp ren=%0b addr=%h", n, imem_ren, imem_addr, bp_pc, m_ren(), m_pc);
      end
      cnt_total++;
      if (fetch_busy !== (m_ren() && imem_busy && !m_drain)) begin
        cnt_bad++; $display("FAIL rand_fetch_busy cyc=%0d got=%0b exp=%0b", n, fetch_busy, m_ren() && imem_busy && !m_drain);
      end
      step();
      cnt_total++;
      if (fe_valid !== m_fe.v) begin
        cnt_bad++; $display("FAIL rand_fe_valid cyc=%0d got=%0b exp=%0b", n, fe_valid, m_fe.v);
      end
      cnt_total++;
      if ({fe_valid, fe_prediction, fe_mal_insn, fe_fault_insn, fe_pc, fe_pc4, fe_instr, fe_badaddr} !== m_fe) begin
        cnt_bad++;
        $display("FAIL rand_fe_reg cyc=%0d got=%h exp=%h", n,
                 {fe_valid, fe_prediction, fe_mal_insn, fe_fault_insn, fe_pc, fe_pc4, fe_instr, fe_badaddr}, m_fe);
      end
    end
    clr_inputs();
  endtask

  initial begin
    nRST = 0;
    clr_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_predict();
    test_redirect_drain();
    test_stall();
    test_fault();
    test_mal();
    test_reset_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", cnt_total, cnt_bad);
    $fatal(1, "timeout");
  end

endmodule
